tri_setup: RTL and testbench

Triangle setup stage between the vertex register file on the Avalon slave and the shader. On `start` it captures three screen-space vertices and computes three edge-function coefficient sets, twice the signed area and a clamped pixel bounding box. Orientation is normalised so that a pixel lies inside when all three edge functions are ≥ 0. It then pulses `done` and holds the results stable for the shader to consume.

---
 rtl/tri_pkg.sv | 8 +
 rtl/tri_bbox.sv | 28 ++
 rtl/tri_setup.sv | 152 +++++++++++++++
 tb/tb_tri_setup.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// tri_pkg: shared state encoding and fixed-point widths for triangle setup.
package tri_pkg;
  typedef enum logic [2:0] {IDLE, MUL, COMBINE, ORIENT, DONE} state_t;
  localparam int FRAC_BITS = 4;
  localparam int AB_W = 17;
  localparam int C_W = 33;
  localparam int AREA_W = 35;
endpackage

// File: rtl/tri_bbox.sv
// tri_bbox: one-axis pixel bounds (floor of min, ceiling of max) clamped to the screen edge.
module tri_bbox
  import tri_pkg::*;
#(
  parameter int unsigned LIMIT = 639
) (
  input  logic [15:0] p0_i,
  input  logic [15:0] p1_i,
  input  logic [15:0] p2_i,
  output logic [9:0]  lo_o,
  output logic [9:0]  hi_o
);
  localparam logic [12:0] LIM = 13'(LIMIT);
  logic [15:0] mn01, mx01, mn, mx;
  logic [16:0] up;
  logic [12:0] lo, hi;
  always_comb begin
    mn01 = p0_i < p1_i ? p0_i : p1_i;
    mx01 = p0_i < p1_i ? p1_i : p0_i;
    mn = mn01 < p2_i ? mn01 : p2_i;
    mx = mx01 < p2_i ? p2_i : mx01;
    up = {1'b0, mx} + 17'd15;
    lo = 13'(mn >> FRAC_BITS);
    hi = 13'(up >> FRAC_BITS);
    lo_o = lo > LIM ? LIM[9:0] : lo[9:0];
    hi_o = hi > LIM ? LIM[9:0] : hi[9:0];
  end
endmodule

// File: rtl/tri_setup.sv
// tri_setup: captures three vertices and produces normalised edge equations,
// doubled area and a clamped pixel bounding box using one shared multiplier.
module tri_setup
  import tri_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [15:0]              v1x,
  input  logic [15:0]              v1y,
  input  logic [15:0]              v2x,
  input  logic [15:0]              v2y,
  input  logic [15:0]              v3x,
  input  logic [15:0]              v3y,
  output logic                     busy,
  output logic                     done,
  output logic signed [AB_W-1:0]   a0,
  output logic signed [AB_W-1:0]   a1,
  output logic signed [AB_W-1:0]   a2,
  output logic signed [AB_W-1:0]   b0,
  output logic signed [AB_W-1:0]   b1,
  output logic signed [AB_W-1:0]   b2,
  output logic signed [C_W-1:0]    c0,
  output logic signed [C_W-1:0]    c1,
  output logic signed [C_W-1:0]    c2,
  output logic signed [AREA_W-1:0] area,
  output logic                     flipped,
  output logic                     degenerate,
  output logic [9:0]               bb_xmin,
  output logic [9:0]               bb_xmax,
  output logic [9:0]               bb_ymin,
  output logic [9:0]               bb_ymax
);
  state_t state_q, state_d;
  logic [2:0] idx_q;
  logic [15:0] vx [3], vy [3], x_q [3], y_q [3];
  logic signed [AB_W-1:0] wa_q [3], wb_q [3], ao_q [3], bo_q [3];
  logic signed [C_W-1:0] wc_q [3], co_q [3], c_d [3];
  logic signed [AREA_W-1:0] war_q, area_q, ar_d;
  logic [5:0][31:0] p_q;
  logic [15:0] ma, mb;
  logic [31:0] prod;
  logic flip_q, degen_q, neg;
  logic [9:0] xmin_q, xmax_q, ymin_q, ymax_q, bx_lo, bx_hi, by_lo, by_hi;
  assign vx = '{v1x, v2x, v3x};
  assign vy = '{v1y, v2y, v3y};
  assign neg = war_q[AREA_W-1];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? MUL : IDLE;
      MUL:     state_d = idx_q == 3'd5 ? COMBINE : MUL;
      COMBINE: state_d = ORIENT;
      ORIENT:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  // Fixed product order: MUL0..MUL5 = x1y2, x2y1, x2y3, x3y2, x3y1, x1y3
  always_comb begin
    case (idx_q)
      3'd0:    {ma, mb} = {x_q[0], y_q[1]};
      3'd1:    {ma, mb} = {x_q[1], y_q[0]};
      3'd2:    {ma, mb} = {x_q[1], y_q[2]};
      3'd3:    {ma, mb} = {x_q[2], y_q[1]};
      3'd4:    {ma, mb} = {x_q[2], y_q[0]};
      default: {ma, mb} = {x_q[0], y_q[2]};
    endcase
    prod = 32'(ma) * 32'(mb);
  end
  // After six shifts the oldest product (MUL0) sits in p_q[5]
  always_comb begin
    c_d[0] = $signed({1'b0, p_q[5]}) - $signed({1'b0, p_q[4]});
    c_d[1] = $signed({1'b0, p_q[3]}) - $signed({1'b0, p_q[2]});
    c_d[2] = $signed({1'b0, p_q[1]}) - $signed({1'b0, p_q[0]});
    ar_d = AREA_W'(c_d[0]) + AREA_W'(c_d[1]) + AREA_W'(c_d[2]);
  end
  tri_bbox #(.LIMIT(SCREEN_W - 1)) u_bbx (
    .p0_i(x_q[0]), .p1_i(x_q[1]), .p2_i(x_q[2]), .lo_o(bx_lo), .hi_o(bx_hi)
  );
  tri_bbox #(.LIMIT(SCREEN_H - 1)) u_bby (
    .p0_i(y_q[0]), .p1_i(y_q[1]), .p2_i(y_q[2]), .lo_o(by_lo), .hi_o(by_hi)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      p_q <= '0;
      war_q <= '0;
      area_q <= '0;
      flip_q <= 1'b0;
      degen_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        wa_q[i] <= '0;
        wb_q[i] <= '0;
        wc_q[i] <= '0;
        ao_q[i] <= '0;
        bo_q[i] <= '0;
        co_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        for (int i = 0; i < 3; i++) begin
          x_q[i] <= vx[i];
          y_q[i] <= vy[i];
          wa_q[i] <= $signed({1'b0, vy[i]}) - $signed({1'b0, vy[(i + 1) % 3]});
          wb_q[i] <= $signed({1'b0, vx[(i + 1) % 3]}) - $signed({1'b0, vx[i]});
        end
      end
      if (state_q == MUL) begin
        p_q <= {p_q[4:0], prod};
        idx_q <= idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
      end
      if (state_q == COMBINE) begin
        wc_q <= c_d;
        war_q <= ar_d;
      end
      if (state_q == ORIENT) begin
        for (int i = 0; i < 3; i++) begin
          ao_q[i] <= neg ? -wa_q[i] : wa_q[i];
          bo_q[i] <= neg ? -wb_q[i] : wb_q[i];
          co_q[i] <= neg ? -wc_q[i] : wc_q[i];
        end
        area_q <= neg ? -war_q : war_q;
        flip_q <= neg;
        degen_q <= war_q == '0;
        xmin_q <= bx_lo;
        xmax_q <= bx_hi;
        ymin_q <= by_lo;
        ymax_q <= by_hi;
      end
    end
  end
  assign {a0, a1, a2} = {ao_q[0], ao_q[1], ao_q[2]};
  assign {b0, b1, b2} = {bo_q[0], bo_q[1], bo_q[2]};
  assign {c0, c1, c2} = {co_q[0], co_q[1], co_q[2]};
  assign area = area_q;
  assign flipped = flip_q;
  assign degenerate = degen_q;
  assign {bb_xmin, bb_xmax, bb_ymin, bb_ymax} = {xmin_q, xmax_q, ymin_q, ymax_q};
endmodule

// File: tb/tb_tri_setup.sv
// tb_tri_setup: scoreboard bench; expected results are queued at start and compared on done.
module tb_tri_setup;
  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic [15:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
  logic busy, done, flipped, degenerate;
  logic signed [16:0] a0, a1, a2, b0, b1, b2;
  logic signed [32:0] c0, c1, c2;
  logic signed [34:0] area;
  logic [9:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;

  typedef struct packed {
    logic [2:0][63:0] a, b, c;
    logic [63:0] area;
    logic flipped, degen;
    logic [9:0] xmin, xmax, ymin, ymax;
  } exp_t;

  exp_t sb[$];
  int done_cyc[$];
  int n_vec = 0, n_bad = 0, cyc = 0;

  tri_setup dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
    .busy(busy), .done(done),
    .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
    .c0(c0), .c1(c1), .c2(c2), .area(area),
    .flipped(flipped), .degenerate(degenerate),
    .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint lim(input longint v, input longint m);
    return v > m ? m : v;
  endfunction

  function automatic exp_t model(input longint x1, y1, x2, y2, x3, y3);
    longint x[3], y[3], a[3], b[3], c[3], ar, mnx, mxx, mny, mxy;
    exp_t e;
    x[0] = x1; x[1] = x2; x[2] = x3;
    y[0] = y1; y[1] = y2; y[2] = y3;
    ar = 0;
    mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
    for (int i = 0; i < 3; i++) begin
      int j = (i + 1) % 3;
      a[i] = y[i] - y[j];
      b[i] = x[j] - x[i];
      c[i] = x[i] * y[j] - x[j] * y[i];
      ar += c[i];
      if (x[i] < mnx) mnx = x[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] < mny) mny = y[i];
      if (y[i] > mxy) mxy = y[i];
    end
    e = '0;
    e.flipped = ar < 0;
    e.degen = ar == 0;
    for (int i = 0; i < 3; i++) begin
      e.a[i] = e.flipped ? -a[i] : a[i];
      e.b[i] = e.flipped ? -b[i] : b[i];
      e.c[i] = e.flipped ? -c[i] : c[i];
    end
    e.area = e.flipped ? -ar : ar;
    e.xmin = 10'(lim(mnx / 16, 639));
    e.xmax = 10'(lim((mxx + 15) / 16, 639));
    e.ymin = 10'(lim(mny / 16, 479));
    e.ymax = 10'(lim((mxy + 15) / 16, 479));
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      exp_t e;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("a0", a0, e.a[0]); chk("a1", a1, e.a[1]); chk("a2", a2, e.a[2]);
        chk("b0", b0, e.b[0]); chk("b1", b1, e.b[1]); chk("b2", b2, e.b[2]);
        chk("c0", c0, e.c[0]); chk("c1", c1, e.c[1]); chk("c2", c2, e.c[2]);
        chk("area", area, e.area);
        chk("flipped", flipped, e.flipped);
        chk("degenerate", degenerate, e.degen);
        chk("bb_xmin", bb_xmin, e.xmin); chk("bb_xmax", bb_xmax, e.xmax);
        chk("bb_ymin", bb_ymin, e.ymin); chk("bb_ymax", bb_ymax, e.ymax);
      end
    end
  end

  task automatic set_v(input logic [15:0] p1x, p1y, p2x, p2y, p3x, p3y);
    v1x = p1x; v1y = p1y; v2x = p2x; v2y = p2y; v3x = p3x; v3y = p3y;
  endtask

  task automatic run(input logic [15:0] p1x, p1y, p2x, p2y, p3x, p3y, input string tag);
    int k;
    @(posedge clk); #1;
    set_v(p1x, p1y, p2x, p2y, p3x, p3y);
    start = 1'b1;
    sb.push_back(model(p1x, p1y, p2x, p2y, p3x, p3y));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    chk({tag, "_lat"}, k, 8);
    @(posedge clk); #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    longint e0, e1, e2;
    int n0;
    logic [15:0] r [6];
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_a1", a1, 0); chk("rst_c1", c1, 0); chk("rst_area", area, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    run(16'h0, 16'h0, 16'h100, 16'h0, 16'h0, 16'h100, "right");
    chk("right_a1", a1, -256); chk("right_b0", b0, 256); chk("right_c1", c1, 65536);
    chk("right_area", area, 65536); chk("right_xmax", bb_xmax, 16); chk("right_ymax", bb_ymax, 16);

    run(16'h0, 16'h0, 16'h0, 16'h100, 16'h100, 16'h0, "swap");
    chk("swap_flip", flipped, 1); chk("swap_area", area, 65536);
    chk("swap_a0", a0, 256); chk("swap_b0", b0, 0); chk("swap_c0", c0, 0);
    e0 = longint'(a0) * 16 + longint'(b0) * 16 + longint'(c0);
    e1 = longint'(a1) * 16 + longint'(b1) * 16 + longint'(c1);
    e2 = longint'(a2) * 16 + longint'(b2) * 16 + longint'(c2);
    chk("swap_e0_pos", longint'(e0 > 0), 1);
    chk("swap_e1_pos", longint'(e1 > 0), 1);
    chk("swap_e2_pos", longint'(e2 > 0), 1);

    run(16'h0, 16'h0, 16'h100, 16'h100, 16'h200, 16'h200, "collinear");
    chk("col_degen", degenerate, 1); chk("col_area", area, 0); chk("col_flip", flipped, 0);

    run(16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, "clamp");
    chk("clamp_xmax", bb_xmax, 639); chk("clamp_ymax", bb_ymax, 479); chk("clamp_xmin", bb_xmin, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 6; i++) r[i] = 16'($urandom_range(0, 16'hFFFF));
      run(r[0], r[1], r[2], r[3], r[4], r[5], "rand");
    end

    // Extra start pulses and vertex changes during MUL must not disturb the run
    for (int i = 0; i < 6; i++) r[i] = 16'($urandom_range(0, 16'h3FFF));
    n0 = done_cyc.size();
    @(posedge clk); #1;
    set_v(r[0], r[1], r[2], r[3], r[4], r[5]);
    start = 1'b1;
    sb.push_back(model(r[0], r[1], r[2], r[3], r[4], r[5]));
    @(posedge clk); #1 start = 1'b0;
    set_v(16'h1234, 16'h0, 16'h0, 16'h777, 16'h42, 16'h42);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("pulse_one_done", done_cyc.size() - n0, 1);

    // start held high: three runs spaced 10 cycles apart
    n0 = done_cyc.size();
    @(posedge clk); #1;
    set_v(16'h0, 16'h0, 16'h100, 16'h0, 16'h0, 16'h100);
    start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(0, 0, 16'h100, 0, 0, 16'h100));
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("held_count", done_cyc.size() - n0, 3);
    if (done_cyc.size() >= n0 + 3) begin
      chk("held_period1", done_cyc[n0 + 1] - done_cyc[n0], 10);
      chk("held_period2", done_cyc[n0 + 2] - done_cyc[n0 + 1], 10);
    end

    // Reset during MUL index 3 clears everything at once
    @(posedge clk); #1;
    set_v(16'h0, 16'h100, 16'h200, 16'h0, 16'h0, 16'h0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    chk("mrst_a1", a1, 0); chk("mrst_b0", b0, 0); chk("mrst_c1", c1, 0);
    chk("mrst_area", area, 0); chk("mrst_xmax", bb_xmax, 0); chk("mrst_ymax", bb_ymax, 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    n0 = done_cyc.size();
    repeat (15) @(posedge clk);
    #1 chk("mrst_no_done", done_cyc.size() - n0, 0);
    run(16'h0, 16'h0, 16'h100, 16'h0, 16'h0, 16'h100, "after_rst");
    chk("after_rst_c1", c1, 65536); chk("after_rst_area", area, 65536);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
